// File: rtl/sea_de_iter_if.sv
// ----------------------------------------------------------------------------
// sea_de_iter_if : block-in, plaintext-out and round-key RAM bus of sea_de_iter
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface sea_de_iter_if #(
  parameter int RAW = 5
);
  logic           in_valid;
  logic           in_ready;
  logic [47:0]    in_l;
  logic [47:0]    in_r;
  logic [RAW-1:0] key_addr;
  logic [47:0]    key_data;
  logic           out_valid;
  logic           out_ready;
  logic [47:0]    out_l;
  logic [47:0]    out_r;

  modport master (
    output in_valid, in_l, in_r, key_data, out_ready,
    input  in_ready, key_addr, out_valid, out_l, out_r
  );

  modport slave (
    input  in_valid, in_l, in_r, key_data, out_ready,
    output in_ready, key_addr, out_valid, out_l, out_r
  );
endinterface

`default_nettype wire

// File: rtl/sea_de_iter.sv
// ----------------------------------------------------------------------------
// sea_de_iter : iterative 96-bit SEA decryption, one sea_de round per cycle
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sea_de (
  input  logic        clk,
  input  logic [47:0] nli,
  input  logic [47:0] nri,
  input  logic [47:0] ki,
  output logic [47:0] li,
  output logic [47:0] ri
);
  // The stage is purely combinational; clk is kept for drop-in compatibility.
  logic unused_clk;
  assign unused_clk = clk;

  function automatic logic [2:0] sbox3(input logic [2:0] x);
    case (x)
      3'd0:    sbox3 = 3'd0;
      3'd1:    sbox3 = 3'd5;
      3'd2:    sbox3 = 3'd6;
      3'd3:    sbox3 = 3'd7;
      3'd4:    sbox3 = 3'd4;
      3'd5:    sbox3 = 3'd3;
      3'd6:    sbox3 = 3'd1;
      default: sbox3 = 3'd2;
    endcase
  endfunction

  logic [47:0] w_m;
  logic [47:0] w_s;
  logic [47:0] w_ro;
  logic [47:0] w_xo;

  assign w_m = nli ^ ki;

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    assign w_s[3*g +: 3] = sbox3(w_m[3*g +: 3]);
  end

  assign w_ro = {w_s[46:0], w_s[47]};
  assign w_xo = w_ro ^ nri;
  assign li   = {w_xo[39:0], w_xo[47:40]};
  assign ri   = nli;
endmodule

module sea_de_iter #(
  parameter int NR  = 8,
  parameter int RAW = 5
) (
  input  logic          clk,
  input  logic          rst,
  sea_de_iter_if.slave  bus,
  output logic          busy
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RND   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [RAW-1:0] C_LAST = RAW'(NR - 1);

  state_t         r_state, state_n;
  logic [47:0]    r_l, r_r, l_n, r_n;
  logic [RAW-1:0] r_addr, addr_n, w_addr_dec;
  logic [RAW-1:0] r_cnt, cnt_n;
  logic [47:0]    w_li, w_ri;

  sea_de u_round (
    .clk (clk),
    .nli (r_l),
    .nri (r_r),
    .ki  (bus.key_data),
    .li  (w_li),
    .ri  (w_ri)
  );

  // Address floors at 0; fetches past the last key are never consumed.
  assign w_addr_dec = (r_addr == '0) ? '0 : r_addr - 1'b1;

  always_comb begin
    state_n = r_state;
    l_n     = r_l;
    r_n     = r_r;
    addr_n  = r_addr;
    cnt_n   = r_cnt;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          l_n     = bus.in_l;
          r_n     = bus.in_r;
          addr_n  = C_LAST;
          cnt_n   = '0;
          state_n = PRIME;
        end
      end
      PRIME: begin
        addr_n  = w_addr_dec;
        state_n = RND;
      end
      RND: begin
        l_n    = w_li;
        r_n    = w_ri;
        addr_n = w_addr_dec;
        cnt_n  = r_cnt + 1'b1;
        if (r_cnt == C_LAST) state_n = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_l     <= '0;
      r_r     <= '0;
      r_addr  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= state_n;
      r_l     <= l_n;
      r_r     <= r_n;
      r_addr  <= addr_n;
      r_cnt   <= cnt_n;
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_l     = r_l;
  assign bus.out_r     = r_r;
  assign bus.key_addr  = r_addr;
  assign busy          = (r_state == PRIME) || (r_state == RND);
endmodule

`default_nettype wire

// File: tb/tb_sea_de_iter.sv
// ----------------------------------------------------------------------------
// tb_sea_de_iter : randomized self-checking bench for sea_de_iter (NR=8 and NR=1)
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sea_de_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy8, busy1;
  int   total = 0;
  int   bad   = 0;

  logic [47:0] ram [32];
  logic [2:0]  sb  [8] = '{3'd0, 3'd5, 3'd6, 3'd7, 3'd4, 3'd3, 3'd1, 3'd2};

  always #5 clk = ~clk;

  sea_de_iter_if #(.RAW(5)) b8 ();
  sea_de_iter_if #(.RAW(5)) b1 ();

  sea_de_iter #(.NR(8), .RAW(5)) dut8 (.clk(clk), .rst(rst), .bus(b8.slave), .busy(busy8));
  sea_de_iter #(.NR(1), .RAW(5)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave), .busy(busy1));

  // Synchronous key RAM: data for the previous cycle's address.
  always @(posedge clk) begin
    b8.key_data <= ram[b8.key_addr];
    b1.key_data <= ram[b1.key_addr];
  end

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] rnd48();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[47:0];
  endfunction

  function automatic logic [95:0] round_ref(input logic [47:0] l, input logic [47:0] r,
                                            input logic [47:0] k);
    logic [47:0] m, s, ro, xo;
    m = l ^ k;
    for (int g = 0; g < 16; g++) s[3*g +: 3] = sb[m[3*g +: 3]];
    ro = {s[46:0], s[47]};
    xo = ro ^ r;
    return {xo[39:0], xo[47:40], l};
  endfunction

  function automatic logic [95:0] decrypt_ref(input logic [47:0] l, input logic [47:0] r,
                                              input int nr);
    logic [95:0] st;
    st = {l, r};
    for (int j = 0; j < nr; j++) st = round_ref(st[95:48], st[47:0], ram[nr-1-j]);
    return st;
  endfunction

  // Entered and left just after a negedge with dut8 idle.
  task automatic run8(input logic [47:0] l, input logic [47:0] r, input int hold,
                      input string tag);
    logic [95:0] exp;
    logic [95:0] held;
    int c;
    exp = decrypt_ref(l, r, 8);
    chk({tag, "_idle_ready"}, 96'(b8.in_ready), 96'd1);
    b8.in_valid  = 1'b1;
    b8.in_l      = l;
    b8.in_r      = r;
    b8.out_ready = (hold == 0);
    c = 0;
    do begin
      @(negedge clk);
      c++;
      // Keep in_valid up during backpressure runs to show it is ignored.
      if (hold == 0) b8.in_valid = 1'b0;
      if (c <= 9) chk({tag, "_addr"}, 96'(b8.key_addr), 96'((8 - c) > 0 ? (8 - c) : 0));
      if (c <= 9) chk({tag, "_busy"}, 96'(busy8), 96'd1);
    end while (!b8.out_valid && c < 40);
    chk({tag, "_lat"}, 96'(c), 96'd10);
    chk({tag, "_out"}, {b8.out_l, b8.out_r}, exp);
    held = {b8.out_l, b8.out_r};
    for (int h = 0; h < hold; h++) begin
      chk({tag, "_hold_out"}, {b8.out_l, b8.out_r}, held);
      chk({tag, "_hold_vld"}, 96'(b8.out_valid), 96'd1);
      chk({tag, "_hold_rdy"}, 96'(b8.in_ready), 96'd0);
      @(negedge clk);
    end
    b8.out_ready = 1'b1;
    b8.in_valid  = 1'b0;
    @(negedge clk);
    chk({tag, "_back_idle"}, 96'(b8.in_ready), 96'd1);
    chk({tag, "_vld_drop"}, 96'(b8.out_valid), 96'd0);
  endtask

  initial begin
    logic [47:0] al, ar, bl, br;
    logic [95:0] exps [2];
    int acc, nout, t0, t1, c;
    logic seen;

    b8.in_valid = 1'b0; b8.in_l = '0; b8.in_r = '0; b8.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.in_l = '0; b1.in_r = '0; b1.out_ready = 1'b1;
    for (int a = 0; a < 32; a++) ram[a] = 48'(a);

    repeat (2) @(negedge clk);
    chk("rst_vld", 96'(b8.out_valid), 96'd0);
    chk("rst_busy", 96'(busy8), 96'd0);
    chk("rst_addr", 96'(b8.key_addr), 96'd0);
    chk("rst_lr", {b8.out_l, b8.out_r}, 96'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 96'(b8.in_ready), 96'd1);

    run8(48'h0123456789AB, 48'hFEDCBA987654, 0, "dir");

    for (int a = 0; a < 32; a++) ram[a] = '0;
    run8(48'h0, 48'h0, 0, "zero");

    for (int a = 0; a < 32; a++) ram[a] = 48'(a);
    run8(48'h0123456789AB, 48'hFEDCBA987654, 5, "bp");

    for (int i = 0; i < 4; i++) begin
      for (int a = 0; a < 8; a++) ram[a] = rnd48();
      run8(rnd48(), rnd48(), int'($urandom_range(0, 4)), "rand");
    end

    // Back-to-back with in_valid held high.
    al = rnd48(); ar = rnd48(); bl = rnd48(); br = rnd48();
    exps[0] = decrypt_ref(al, ar, 8);
    exps[1] = decrypt_ref(bl, br, 8);
    acc = 0; nout = 0; t0 = 0; t1 = 0;
    b8.out_ready = 1'b1;
    for (int t = 0; t < 60 && nout < 2; t++) begin
      b8.in_valid = (acc < 2);
      b8.in_l = (acc == 0) ? al : bl;
      b8.in_r = (acc == 0) ? ar : br;
      if (b8.out_valid) begin
        chk("b2b_out", {b8.out_l, b8.out_r}, exps[nout]);
        nout++;
      end
      if (b8.in_valid && b8.in_ready) begin
        if (acc == 0) t0 = t; else t1 = t;
        acc++;
      end
      @(negedge clk);
    end
    b8.in_valid = 1'b0;
    chk("b2b_nout", 96'(nout), 96'd2);
    chk("b2b_gap", 96'(t1 - t0), 96'd11);

    // NR=1 instance: single round with key word 0.
    ram[0] = rnd48();
    al = rnd48(); ar = rnd48();
    b1.in_valid = 1'b1; b1.in_l = al; b1.in_r = ar;
    c = 0;
    do begin
      @(negedge clk);
      c++;
      b1.in_valid = 1'b0;
      if (c <= 2) chk("nr1_addr", 96'(b1.key_addr), 96'd0);
    end while (!b1.out_valid && c < 20);
    chk("nr1_lat", 96'(c), 96'd3);
    chk("nr1_out", {b1.out_l, b1.out_r}, round_ref(al, ar, ram[0]));
    @(negedge clk);

    // Reset in the middle of round 3.
    b8.in_valid = 1'b1; b8.in_l = rnd48(); b8.in_r = rnd48(); b8.out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      b8.in_valid = 1'b0;
    end
    chk("mid_busy_pre", 96'(busy8), 96'd1);
    rst = 1'b1;
    #1;
    chk("mid_vld", 96'(b8.out_valid), 96'd0);
    chk("mid_busy", 96'(busy8), 96'd0);
    chk("mid_addr", 96'(b8.key_addr), 96'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_ready", 96'(b8.in_ready), 96'd1);
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (b8.out_valid) seen = 1'b1;
    end
    chk("mid_no_vld", 96'(seen), 96'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
